regfile_param: RTL

Parametrised two-read/one-write register file, the next generation of the 32x32 register block in the datapath. It adds configurable width and depth, per-byte write enables, an optional hard-wired zero entry, and optional write-to-read forwarding. It also runs a sequential clear sweep, so the storage array carries no reset and maps onto RAM. It sits between decode (read selects) and writeback (write port) and feeds the ALU operand registers.

---
 rtl/regfile_param_if.sv | 29 ++
 rtl/regfile_param.sv | 90 +++++++++
 2 files changed

// File: rtl/regfile_param_if.sv
// Register file port bundle: decode-side read selects, writeback write port,
// clear request, and the registered read data / ready status.
interface regfile_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  localparam int NB = DATA_W / 8;

  logic [ADDR_W-1:0] rdsel1;
  logic [ADDR_W-1:0] rdsel2;
  logic [ADDR_W-1:0] wtsel;
  logic [DATA_W-1:0] wtdata;
  logic              wenable;
  logic [NB-1:0]     wbe;
  logic              clr;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              ready;

  modport master (
    output rdsel1, rdsel2, wtsel, wtdata, wenable, wbe, clr,
    input  rdata1, rdata2, ready
  );

  modport slave (
    input  rdsel1, rdsel2, wtsel, wtdata, wenable, wbe, clr,
    output rdata1, rdata2, ready
  );
endinterface

// File: rtl/regfile_param.sv
// Two-read/one-write register file with byte enables, optional zero entry,
// optional write forwarding and a sequential clear sweep (array has no reset).
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  regfile_param_if.slave  bus
);
  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd1_q, rd2_q;
  logic [DATA_W-1:0] rd1_v, rd2_v;
  logic [DATA_W-1:0] be_mask;
  logic              wr_ok;

  // A write commits only in RUN, not alongside a clear request, and never to a hard-wired zero entry.
  assign wr_ok = (state == RUN) && bus.wenable && !bus.clr &&
                 !(ZERO_REG && (bus.wtsel == '0));

  for (genvar k = 0; k < NB; k++) begin : g_lane
    assign be_mask[8*k +: 8] = {8{bus.wbe[k]}};
  end

  always_comb begin
    rd1_v = mem[bus.rdsel1];
    if (BYPASS && wr_ok && (bus.wtsel == bus.rdsel1))
      rd1_v = (rd1_v & ~be_mask) | (bus.wtdata & be_mask);
    if (ZERO_REG && (bus.rdsel1 == '0))
      rd1_v = '0;

    rd2_v = mem[bus.rdsel2];
    if (BYPASS && wr_ok && (bus.wtsel == bus.rdsel2))
      rd2_v = (rd2_v & ~be_mask) | (bus.wtdata & be_mask);
    if (ZERO_REG && (bus.rdsel2 == '0))
      rd2_v = '0;
  end

  // Storage carries no reset so it can map onto RAM; the sweep initialises it.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_ptr] <= '0;
    end else if (wr_ok) begin
      for (int k = 0; k < NB; k++)
        if (bus.wbe[k])
          mem[bus.wtsel][8*k +: 8] <= bus.wtdata[8*k +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
    end else begin
      case (state)
        CLEAR: begin
          rd1_q   <= '0;
          rd2_q   <= '0;
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == '1)
            state <= RUN;
        end
        default: begin
          rd1_q <= rd1_v;
          rd2_q <= rd2_v;
          if (bus.clr) begin
            state   <= CLEAR;
            clr_ptr <= '0;
          end
        end
      endcase
    end
  end

  assign bus.rdata1 = rd1_q;
  assign bus.rdata2 = rd2_q;
  assign bus.ready  = (state == RUN);
endmodule
